// File: rtl/msb_cfg_switch.sv
// msb_cfg_switch: input-to-output router whose selectors load over a handshake into a shadow register and commit atomically
module msb_cfg_switch #(
   parameter int NB_INPUTS  = 40,
   parameter int NB_OUTPUTS = 8,
   parameter int DATA_SIZE  = 8,
   parameter bit OUT_REG    = 1'b0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_cfg_start,
   input  logic                  i_cfg_valid,
   output logic                  o_cfg_ready,
   input  logic [DATA_SIZE-1:0]  i_data,
   output logic                  o_cfg_done,
   output logic                  o_sel_err,
   input  logic [NB_INPUTS-1:0]  i_inputs,
   output logic [NB_OUTPUTS-1:0] o_outputs
);
   localparam int SEL_W    = (NB_INPUTS > 1) ? $clog2(NB_INPUTS) : 1;
   localparam int CFG_BITS = NB_OUTPUTS * SEL_W;
   localparam int NB_WORDS = (CFG_BITS + DATA_SIZE - 1) / DATA_SIZE;
   localparam int CNT_W    = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
   localparam int PAD_W    = 2 ** SEL_W;
   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
   state_t                r_state, w_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [CFG_BITS-1:0]   r_shadow, r_active;
   logic [PAD_W-1:0]      w_pad, w_vmask;
   logic [NB_OUTPUTS-1:0] w_route, r_out;
   logic                  w_err, w_last, r_sel_err, r_done;
   // Zero-padding the inputs to a power of two makes out-of-range selectors read 0
   assign w_pad       = PAD_W'(i_inputs);
   assign w_vmask     = PAD_W'({NB_INPUTS{1'b1}});
   assign w_last      = r_cnt == CNT_W'(NB_WORDS - 1);
   assign o_cfg_ready = r_state == LOAD;
   assign o_cfg_done  = r_done;
   assign o_sel_err   = r_sel_err;
   assign o_outputs   = OUT_REG ? r_out : w_route;
   always_comb begin
      w_route = '0;
      w_err   = 1'b0;
      for (int i = 0; i < NB_OUTPUTS; i++) begin
         w_route[i] = w_pad[r_active[i*SEL_W +: SEL_W]];
         w_err      = w_err | ~w_vmask[r_active[i*SEL_W +: SEL_W]];
      end
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = i_cfg_start ? LOAD : IDLE;
         LOAD:    w_next = (!i_cfg_start && i_cfg_valid && w_last) ? COMMIT : LOAD;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_shadow  <= '0;
         r_active  <= '0;
         r_done    <= 1'b0;
         r_sel_err <= 1'b0;
         r_out     <= '0;
      end else begin
         r_state   <= w_next;
         r_done    <= r_state == COMMIT;
         r_sel_err <= w_err;
         r_out     <= w_route;
         if (r_state == COMMIT) r_active <= r_shadow;
         if (r_state != LOAD || i_cfg_start) r_cnt <= '0;
         else if (i_cfg_valid) begin
            r_cnt <= r_cnt + 1'b1;
            for (int b = 0; b < CFG_BITS; b++)
               if (CNT_W'(b / DATA_SIZE) == r_cnt) r_shadow[b] <= i_data[b % DATA_SIZE];
         end
      end
   end
endmodule

// File: tb/tb_msb_cfg_switch.sv
// tb_msb_cfg_switch: directed vectors for the config-loaded router, registered and combinational output variants
module tb_msb_cfg_switch;
   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic [4:0] inp = 5'b11111;
   logic       rdy_r, dn_r, er_r, rdy_c, dn_c, er_c;
   logic [3:0] out_r, out_c;
   int         n_vec = 0, n_err = 0;
   typedef struct {
      logic       s, v;
      logic [7:0] d;
      logic [4:0] in;
      logic       rdy, dn, er;
      logic [3:0] o_r, o_c;
   } vec_t;
   vec_t tbl [16];
   always #5 clk = ~clk;
   msb_cfg_switch #(.NB_INPUTS(5), .NB_OUTPUTS(4), .DATA_SIZE(8), .OUT_REG(1'b1)) dut_r (
      .i_clk(clk), .i_rst(rst), .i_cfg_start(start), .i_cfg_valid(valid), .o_cfg_ready(rdy_r),
      .i_data(data), .o_cfg_done(dn_r), .o_sel_err(er_r), .i_inputs(inp), .o_outputs(out_r));
   msb_cfg_switch #(.NB_INPUTS(5), .NB_OUTPUTS(4), .DATA_SIZE(8), .OUT_REG(1'b0)) dut_c (
      .i_clk(clk), .i_rst(rst), .i_cfg_start(start), .i_cfg_valid(valid), .o_cfg_ready(rdy_c),
      .i_data(data), .o_cfg_done(dn_c), .o_sel_err(er_c), .i_inputs(inp), .o_outputs(out_c));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic s, input logic v, input logic [7:0] d);
      start = s;
      valid = v;
      data  = d;
   endtask
   task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask
   task automatic chk_all(input string tag, input logic rdy, input logic dn, input logic er,
                          input logic [3:0] o_r, input logic [3:0] o_c);
      chk({tag, " ready_r"}, {3'b0, rdy_r}, {3'b0, rdy});
      chk({tag, " ready_c"}, {3'b0, rdy_c}, {3'b0, rdy});
      chk({tag, " done_r"},  {3'b0, dn_r},  {3'b0, dn});
      chk({tag, " done_c"},  {3'b0, dn_c},  {3'b0, dn});
      chk({tag, " err_r"},   {3'b0, er_r},  {3'b0, er});
      chk({tag, " err_c"},   {3'b0, er_c},  {3'b0, er});
      chk({tag, " out_r"},   out_r, o_r);
      chk({tag, " out_c"},   out_c, o_c);
   endtask
   // Full two-beat frame; oc is the routing expected once the new cfg is active
   task automatic load(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [3:0] oc);
      drive(1'b1, 1'b0, 8'h00); tick();
      drive(1'b0, 1'b1, b0);    tick();
      drive(1'b0, 1'b1, b1);    tick();
      drive(1'b0, 1'b0, 8'h00); tick();
      chk({tag, " done"}, {3'b0, dn_r}, 4'b0001);
      chk({tag, " out_c"}, out_c, oc);
      tick();
      chk_all({tag, " settled"}, 1'b0, 1'b0, 1'b0, oc, oc);
   endtask
   initial begin
      tbl[0]  = '{1'b0, 1'b0, 8'h00, 5'b11111, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111};
      tbl[1]  = '{1'b1, 1'b0, 8'h00, 5'b01010, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
      tbl[2]  = '{1'b0, 1'b1, 8'h88, 5'b01010, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
      tbl[3]  = '{1'b0, 1'b1, 8'h06, 5'b01010, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
      tbl[4]  = '{1'b0, 1'b0, 8'h00, 5'b01010, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1010};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 5'b01010, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010};
      tbl[6]  = '{1'b1, 1'b0, 8'h00, 5'b01010, 1'b1, 1'b0, 1'b0, 4'b1010, 4'b1010};
      tbl[7]  = '{1'b0, 1'b1, 8'hFF, 5'b01010, 1'b1, 1'b0, 1'b0, 4'b1010, 4'b1010};
      tbl[8]  = '{1'b0, 1'b1, 8'hFF, 5'b01010, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 5'b01010, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0000};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 5'b01010, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000};
      tbl[11] = '{1'b1, 1'b0, 8'h00, 5'b01010, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000};
      tbl[12] = '{1'b0, 1'b1, 8'h88, 5'b01010, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000};
      tbl[13] = '{1'b0, 1'b1, 8'h06, 5'b01010, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000};
      tbl[14] = '{1'b0, 1'b0, 8'h00, 5'b01010, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1010};
      tbl[15] = '{1'b0, 1'b0, 8'h00, 5'b01010, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010};
      repeat (2) tick();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111);
      rst = 1'b0;
      chk_all("post-reset", 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111);
      for (int k = 0; k < 16; k++) begin
         drive(tbl[k].s, tbl[k].v, tbl[k].d);
         inp = tbl[k].in;
         tick();
         chk_all($sformatf("vec%0d", k), tbl[k].rdy, tbl[k].dn, tbl[k].er, tbl[k].o_r, tbl[k].o_c);
      end
      inp = 5'b10101;
      load("sel4", 8'h24, 8'h09, 4'b1111);
      drive(1'b1, 1'b0, 8'h00); tick(); chk_all("rs start", 1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111);
      drive(1'b0, 1'b1, 8'h24); tick(); chk_all("rs beat0", 1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111);
      drive(1'b1, 1'b1, 8'hFF); tick(); chk_all("rs restart", 1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111);
      drive(1'b0, 1'b1, 8'h88); tick(); chk_all("rs beat0b", 1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111);
      drive(1'b0, 1'b1, 8'h06); tick(); chk_all("rs beat1b", 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111);
      drive(1'b1, 1'b0, 8'h00); tick(); chk_all("commit start", 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0101);
      drive(1'b1, 1'b0, 8'h00); tick(); chk_all("b2b start", 1'b1, 1'b0, 1'b0, 4'b0101, 4'b0101);
      drive(1'b0, 1'b1, 8'h24); tick(); chk_all("part beat", 1'b1, 1'b0, 1'b0, 4'b0101, 4'b0101);
      drive(1'b0, 1'b0, 8'h00);
      rst = 1'b1; tick(); chk_all("mid rst", 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111);
      rst = 1'b0; tick(); chk_all("after rst", 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111);
      tick(); chk_all("no done", 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111);
      load("reload", 8'h88, 8'h06, 4'b0101);
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b1, 8'($urandom));
         tick();
         chk_all($sformatf("idle%0d", k), 1'b0, 1'b0, 1'b0, 4'b0101, 4'b0101);
      end
      drive(1'b0, 1'b0, 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
